// File: rtl/imm_encoder.sv
// Iterative inverse of the decode-stage extender: finds the 25-bit immediate
// field that expands back to a given 32-bit constant for the selected ImmSrc.
module imm_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  ImmSrc,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic [24:0] field,
    output logic        fits
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  r_q, r_d;
    logic [31:0] val_q, val_d;
    logic [24:0] field_q, field_d;
    logic        fits_q, fits_d;
    logic [31:0] t;

    // Rotating left by 2*r undoes the decoder's ROR, exposing the imm8 candidate.
    function automatic logic [31:0] rotl_even(input logic [31:0] v, input logic [3:0] r);
        logic [63:0] w;
        w = {v, v} << {r, 1'b0};
        return w[63:32];
    endfunction

    assign t = rotl_even(val_q, r_q);

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        val_d   = val_q;
        field_d = field_q;
        fits_d  = fits_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    val_d = value;
                    r_d   = 4'd0;
                    case (ImmSrc)
                        2'b00: begin
                            fits_d  = (value[31:11] == '0) || (value[31:11] == '1);
                            field_d = {13'b0, value[11:0]};
                            state_d = S_DONE;
                        end
                        2'b01: begin
                            state_d = S_SEARCH;
                        end
                        2'b10: begin
                            fits_d  = (value[1:0] == 2'b00) && (value[31:26] == {6{value[25]}});
                            field_d = {1'b0, value[25:2]};
                            state_d = S_DONE;
                        end
                        default: begin
                            fits_d  = 1'b0;
                            field_d = '0;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_SEARCH: begin
                if (t[31:8] == '0) begin
                    field_d = {13'b0, r_q, t[7:0]};
                    fits_d  = 1'b1;
                    state_d = S_DONE;
                end else if (r_q == 4'd15) begin
                    field_d = '0;
                    fits_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    r_d = r_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            r_q     <= 4'd0;
            val_q   <= '0;
            field_q <= '0;
            fits_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            val_q   <= val_d;
            field_q <= field_d;
            fits_q  <= fits_d;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign field = field_q;
    assign fits  = fits_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed and random bench for imm_encoder; results are checked against a
// queued reference model and round-tripped through a behavioural extender.
module tb_imm_encoder;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  ImmSrc;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic [24:0] field;
    logic        fits;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [24:0] fld;
        bit          ft;
        int          lat;
    } exp_t;

    exp_t sb[$];

    imm_encoder dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .ImmSrc (ImmSrc),
        .value  (value),
        .busy   (busy),
        .done   (done),
        .field  (field),
        .fits   (fits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        logic [31:0] o;
        for (int i = 0; i < 32; i++) o[(i + n) % 32] = x[i];
        return o;
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [31:0] o;
        for (int i = 0; i < 32; i++) o[i] = x[(i + n) % 32];
        return o;
    endfunction

    function automatic logic [31:0] extender(input logic [1:0] f, input logic [24:0] fld);
        case (f)
            2'b00:   return {{20{fld[11]}}, fld[11:0]};
            2'b01:   return rotr({24'b0, fld[7:0]}, 2 * int'(fld[11:8]));
            2'b10:   return {{6{fld[23]}}, fld[23:0], 2'b00};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model(input logic [1:0] f, input logic [31:0] v, output exp_t e);
        logic [31:0] cand;
        e.fld = '0;
        e.ft  = 1'b0;
        e.lat = 1;
        case (f)
            2'b00: begin
                e.fld = {13'b0, v[11:0]};
                e.ft  = ({{20{v[11]}}, v[11:0]} == v);
            end
            2'b10: begin
                e.fld = {1'b0, v[25:2]};
                e.ft  = ({{6{v[25]}}, v[25:2], 2'b00} == v);
            end
            2'b01: begin
                e.lat = 17;
                for (int r = 0; r < 16; r++) begin
                    cand = rotl(v, 2 * r);
                    if (!e.ft && rotr({24'b0, cand[7:0]}, 2 * r) == v) begin
                        e.ft  = 1'b1;
                        e.fld = {13'b0, 4'(r), cand[7:0]};
                        e.lat = r + 2;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic run(input logic [1:0] f, input logic [31:0] v, input bit poke,
                       output logic [24:0] ofld, output logic ofit);
        exp_t e;
        exp_t got_e;
        int   lat;
        bit   got;
        model(f, v, e);
        sb.push_back(e);
        @(negedge clk);
        ImmSrc = f;
        value  = v;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        ImmSrc = 2'($urandom);
        value  = $urandom;
        lat = 0;
        got = 1'b0;
        ofld = 'x;
        ofit = 1'bx;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            start = (poke && lat == 2);
            if (done) got = 1'b1;
            else check("busy_during", 32'(busy), 32'd1);
        end
        start = 1'b0;
        got_e = sb.pop_front();
        if (!got) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("field", 32'(field), 32'(got_e.fld));
            check("fits", 32'(fits), 32'(got_e.ft));
            check("latency", 32'(lat), 32'(got_e.lat));
            check("busy_at_done", 32'(busy), 32'd1);
            ofld = field;
            ofit = fits;
            if (fits === 1'b1) check("round_trip", extender(f, field), v);
            @(negedge clk);
            check("done_pulse_end", 32'(done), 32'd0);
            check("busy_after", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        logic [24:0] fo;
        logic        ft;
        logic [31:0] x;
        logic [7:0]  b8;

        reset  = 1'b1;
        start  = 1'b0;
        ImmSrc = 2'b00;
        value  = '0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_field", 32'(field), 32'd0);
        check("rst_fits", 32'(fits), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);

        run(2'b00, 32'hFFFFFAAA, 1'b0, fo, ft);
        check("f00_field", 32'(fo), 32'h0000AAA);
        check("f00_fits", 32'(ft), 32'd1);
        run(2'b00, 32'h00000800, 1'b0, fo, ft);
        check("f00_range", 32'(ft), 32'd0);

        run(2'b01, 32'h000000FF, 1'b0, fo, ft);
        check("f01_ff", 32'(fo), 32'h00FF);
        run(2'b01, 32'hFF000000, 1'b0, fo, ft);
        check("f01_rot4", 32'(fo), 32'h04FF);
        run(2'b01, 32'h00000101, 1'b0, fo, ft);
        check("f01_miss_fits", 32'(ft), 32'd0);
        check("f01_miss_field", 32'(fo), 32'd0);

        run(2'b10, 32'hFFFFFFF8, 1'b0, fo, ft);
        check("f10_field", 32'(fo), 32'h0FFFFFE);
        check("f10_fits", 32'(ft), 32'd1);
        run(2'b10, 32'h00000006, 1'b0, fo, ft);
        check("f10_align", 32'(ft), 32'd0);
        run(2'b10, 32'h04000000, 1'b0, fo, ft);
        check("f10_range", 32'(ft), 32'd0);
        run(2'b11, 32'h12345678, 1'b0, fo, ft);
        check("f11_fits", 32'(ft), 32'd0);

        run(2'b01, 32'hFF000000, 1'b1, fo, ft);
        check("ignored_start", 32'(fo), 32'h04FF);

        // Abandon a search with reset; the previous 0x4FF result must vanish at once.
        @(negedge clk);
        ImmSrc = 2'b01;
        value  = 32'h00000101;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_field", 32'(field), 32'd0);
        check("mid_rst_fits", 32'(fits), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check("no_done_after_rst", 32'(done), 32'd0);
        end
        run(2'b01, 32'h000003FC, 1'b0, fo, ft);
        check("post_rst_fits", 32'(ft), 32'd1);

        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 1000; i++) begin
                x  = $urandom;
                b8 = 8'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    case (f)
                        0: x = {{20{x[11]}}, x[11:0]};
                        1: x = rotr({24'b0, b8}, 2 * int'($urandom_range(0, 15)));
                        default: x = {{6{x[25]}}, x[25:2], 2'b00};
                    endcase
                end
                run(2'(f), x, 1'b0, fo, ft);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Iterative immediate encoder: the inverse of the decode-stage `extender`. Given a 32-bit constant and an `ImmSrc` format, it searches for the 25-bit instruction immediate field that `extender` expands back to that constant. It reports whether the constant is representable in that format. It sits in the assembler/loader path and in the self-checking bench that round-trips values through `extender`.

## Interface
- No parameters. Field width (25) and value width (32) are fixed to match `extender`.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: request; sampled only while `busy`=0.
- `ImmSrc` input 2: format; 00 = 12-bit signed offset, 01 = rotated imm8, 10 = 24-bit branch word offset, 11 = reserved.
- `value` input 32: constant to encode; captured on the accepted `start`.
- `busy` output 1: high from the accepted `start` until `done` has been presented.
- `done` output 1: one-cycle pulse; `field` and `fits` are valid.
- `field` output 25: encoded immediate (`extender` `inp`).
- `fits` output 1: 1 means `field` decodes exactly to `value`.

## Operation
- States are IDLE, SEARCH and DONE. `busy` = (state != IDLE).
- IDLE accepts `start`=1. It latches `value` and `ImmSrc`, clears the rotation counter `r` (4 bits), then branches by format:
  - 00, 10, 11: compute the result in the same edge and go to DONE.
  - 01: go to SEARCH.
- Format 00: `fits` = `value[31:11]` all equal. `field` = {13'b0, `value[11:0]`}.
- Format 10: `fits` = (`value[1:0]`==0) and (`value[31:26]` all equal `value[25]`). `field` = {1'b0, `value[25:2]`}.
- Format 11: `fits`=0 and `field`=0.
- Format 01, decoded as imm8 ROR (2·rot). Each SEARCH cycle tests one candidate:
  - Compute `t` = latched value rotated left by 2·`r`.
  - Hit: `t[31:8]`==0. Register `field` = {13'b0, `r`, `t[7:0]`}, set `fits`=1, go to DONE.
  - Miss with `r`==15: `field`=0, `fits`=0, go to DONE.
  - Otherwise increment `r` and stay in SEARCH.
- The smallest hitting `r` always wins. Value 0 encodes as `field`=0 with `r`=0.
- DONE asserts `done`=1 for exactly one cycle, then returns to IDLE.
- `field` and `fits` hold their values until the next accepted `start` overwrites them.
- `start` while `busy`=1 is ignored: no latch and no queueing. `start` held high in IDLE re-triggers on the cycle after `done`.
- `ImmSrc` and `value` changes after acceptance have no effect.

## Timing
- Reset, asynchronous, any state: state=IDLE, `r`=0, `busy`=0, `done`=0, `field`=0, `fits`=0.
  - An in-flight search is abandoned; no `done` is produced.
  - Outputs stay at reset values until the next accepted `start`.
- Define edge k as the edge where `start` is accepted.
- Formats 00, 10, 11:
  - `field` and `fits` are registered at edge k.
  - `done`=1 and `busy`=1 in the cycle after edge k.
  - IDLE again after edge k+1.
  - Latency is 1 cycle.
- Format 01, hit at rotation r:
  - Result registered at edge k+1+r.
  - `done` high in the cycle after that edge.
  - Latency is r+2 cycles.
- Format 01, no fit: latency is 17 cycles.
- `busy` rises in the cycle after edge k and falls in the cycle after the `done` cycle.
- Back-to-back throughput: one new request every latency+1 cycles.

## Test plan
- Reset and format 00:
  - Stimulus: after reset, check all outputs 0. Then start with `ImmSrc`=00, `value`=0xFFFFFAAA.
  - Required: `done` one cycle later, `field`=0x0000AAA, `fits`=1. `extender` on that field returns 0xFFFFFAAA.
  - Stimulus: `value`=0x00000800. Required: `fits`=0.
- Format 01 hits:
  - `value`=0x000000FF: `field`=0x00FF, `fits`=1, `done` at latency 2.
  - `value`=0xFF000000: `field`=0x04FF (r=4), latency 6.
- Format 01 miss:
  - `value`=0x00000101: `fits`=0, `field`=0, latency 17, `busy` high throughout.
- Format 10:
  - `value`=0xFFFFFFF8: `field`=0x0FFFFFE, `fits`=1.
  - `value`=0x00000006: `fits`=0.
  - `value`=0x04000000: `fits`=0 (out of range).
- Busy and reset interactions:
  - `start` pulsed with a different `value` during a format-01 search: ignored, result matches the first request.
  - `reset` asserted mid-search: outputs 0 immediately, no `done`. A new request afterwards completes normally.
- Random round trip:
  - 1000 random values for each of formats 00, 01 and 10.
  - Required: whenever `fits`=1, `extender`(`ImmSrc`, `field`) == `value`.
  - Required for format 01: `fits` matches a software brute-force check over all 16 rotations.
